// File: rtl/pe_pkg.sv
// Shared definitions for the PE output path: default widths and the
// accumulator FSM state encoding.
package pe_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ACCUM = ST_ACCUM,
        S_DONE  = ST_DONE
    } state_e;

endpackage

// File: rtl/pe_acc_lane.sv
// One accumulator lane: load/add select, optional saturating add with a
// sticky clamp flag (built only when PE_ACC_SAT_EN is defined).
module pe_acc_lane
    import pe_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              add_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  acc_o,
    output logic              sat_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum_c;

    assign prod_ext = ACC_W'($signed(prod_i));

`ifdef PE_ACC_SAT_EN
    logic [ACC_W:0] sum_w;
    logic           ovf;
    logic           sat_q, sat_d;

    // One guard bit: overflow when the guard and the top bit disagree.
    assign sum_w = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
    assign ovf   = sum_w[ACC_W] ^ sum_w[ACC_W-1];

    always_comb begin
        sum_c = sum_w[ACC_W-1:0];
        if (ovf)
            sum_c = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
    end

    always_comb begin
        sat_d = sat_q;
        if (load_i)
            sat_d = 1'b0;
        else if (add_i && ovf)
            sat_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_q <= 1'b0;
        else
            sat_q <= sat_d;
    end

    assign sat_o = sat_q;
`else
    assign sum_c = acc_q + prod_ext;
    assign sat_o = 1'b0;
`endif

    always_comb begin
        acc_d = acc_q;
        if (load_i)
            acc_d = prod_ext;
        else if (add_i)
            acc_d = sum_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/pe_acc.sv
// Per-lane product accumulator with a frame-length FSM and valid/ready result
// handshake. Saturating arithmetic is selected by defining PE_ACC_SAT_EN.
module pe_acc
    import pe_pkg::*;
#(
    parameter int MFU_COUNT = 4,
    parameter int PROD_W    = PROD_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int LEN_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [LEN_W-1:0]           cfg_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [MFU_COUNT*PROD_W-1:0] in_prod,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [MFU_COUNT*ACC_W-1:0] out_data,
    output logic [MFU_COUNT-1:0]       out_sat
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic             in_ready_q, out_valid_q;
    logic             accept;
    logic             lane_load, lane_add;

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        lane_load = 1'b0;
        lane_add  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    len_d     = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                    cnt_d     = (LEN_W+1)'(1);
                    lane_load = 1'b1;
                    state_d   = (len_d == LEN_W'(1)) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    cnt_d    = cnt_q + 1'b1;
                    lane_add = 1'b1;
                    if (cnt_d == {1'b0, len_q})
                        state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake flags are registered decodes of the next state, so they
    // never see out_ready or in_valid combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d != S_DONE);
            out_valid_q <= (state_d == S_DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

    for (genvar i = 0; i < MFU_COUNT; i++) begin : g_lane
        pe_acc_lane #(
            .PROD_W(PROD_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .load_i(lane_load),
            .add_i (lane_add),
            .prod_i(in_prod[i*PROD_W +: PROD_W]),
            .acc_o (out_data[i*ACC_W +: ACC_W]),
            .sat_o (out_sat[i])
        );
    end

endmodule
